// File: rtl/bfm_pkg.sv
// Shared types and constants for the stream-transmitter BFM.
package bfm_pkg;

  // Transmitter control states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] LFSR_POLY    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // One step of the gap LFSR.
  function automatic logic [15:0] lfsr_advance(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/bfm_lfsr16.sv
// 16-bit Galois LFSR that advances one step per 'step' pulse; reloads 'seed' only on reset.
module bfm_lfsr16
  import bfm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // LFSR register: reseeded by reset only, so the gap sequence is reproducible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (step) begin
      q <= lfsr_advance(q);
    end
  end

endmodule

// File: rtl/bfm_stream_xmit.sv
// Stream-transmitter BFM: replays preloaded words onto a valid/ready port with a start
// delay, seeded pseudo-random inter-word gaps, loop mode, abort and a key-load hold.
module bfm_stream_xmit
  import bfm_pkg::*;
#(
  parameter int          DATA_W = 257,
  parameter int          DEPTH  = 32,
  parameter logic [15:0] SEED   = DEFAULT_SEED,
  localparam int         AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_we,
  input  logic [AW-1:0]     ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [AW:0]       cfg_len,
  input  logic [15:0]       cfg_wait,
  input  logic              cfg_gap_en,
  input  logic [7:0]        cfg_gap_max,
  input  logic              cfg_loop,
  input  logic              start,
  input  logic              abort,
  input  logic              hold,
  input  logic              tx_rdy,
  output logic              tx_vld,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_last,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sent_cnt
);

  localparam int LW = AW + 1;

  state_t            state, state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     idx, idx_next;
  logic [15:0]       cnt, cnt_next;
  logic [31:0]       sent_next;
  logic              done_next;
  logic              load_cfg;
  logic              lfsr_step;

  // Run configuration captured at start; later cfg_* changes do not disturb a run.
  logic [LW-1:0]     len_q;
  logic [15:0]       wait_q;
  logic              gap_en_q;
  logic [7:0]        gap_max_q;
  logic              loop_q;

  logic              xfer;
  logic              last_word;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_nx;
  logic [8:0]        gap_mod;
  logic [7:0]        gap_len;

  bfm_lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign busy      = (state != S_IDLE);
  assign tx_vld    = (state == S_SEND) & ~hold;
  assign tx_data   = mem[idx];
  assign xfer      = tx_vld & tx_rdy;
  assign last_word = ({1'b0, idx} == (len_q - LW'(1)));
  assign tx_last   = tx_vld & last_word;

  // Gap length is drawn from the LFSR value that this transfer steps to.
  assign lfsr_nx = lfsr_advance(lfsr_q);
  assign gap_mod = {1'b0, gap_max_q} + 9'd1;
  assign gap_len = 8'(lfsr_nx % {7'd0, gap_mod});

  // Vector memory write port, accepted only while idle.
  // NOTE: the vector memory has no reset; its contents must survive rst_n so a bench can
  // reset mid-run and replay the same vectors.
  always_ff @(posedge clk) begin
    if (ld_we && (state == S_IDLE)) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // Next-state and datapath updates for the transmit FSM; abort overrides everything.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    cnt_next   = cnt;
    sent_next  = sent_cnt;
    done_next  = 1'b0;
    load_cfg   = 1'b0;
    lfsr_step  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          load_cfg  = 1'b1;
          idx_next  = '0;
          sent_next = '0;
          cnt_next  = '0;
          if (cfg_wait != 16'd0) begin
            state_next = S_WAIT;
          end else if (cfg_len != '0) begin
            state_next = S_SEND;
          end else begin
            done_next = 1'b1;
          end
        end
      end

      S_WAIT: begin
        if (cnt == (wait_q - 16'd1)) begin
          cnt_next = '0;
          if (len_q != '0) begin
            state_next = S_SEND;
          end else begin
            state_next = S_IDLE;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end

      S_SEND: begin
        if (xfer) begin
          sent_next = sent_cnt + 32'd1;
          lfsr_step = 1'b1;
          if (last_word) begin
            idx_next = '0;
            if (!loop_q) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end
          end else begin
            idx_next = idx + AW'(1);
            if (gap_en_q && (gap_len != 8'd0)) begin
              state_next = S_GAP;
              cnt_next   = 16'(gap_len);
            end
          end
        end
      end

      S_GAP: begin
        if (cnt == 16'd1) begin
          state_next = S_SEND;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - 16'd1;
        end
      end

      default: state_next = S_IDLE;
    endcase

    if (abort) begin
      state_next = S_IDLE;
      idx_next   = idx;
      cnt_next   = '0;
      sent_next  = sent_cnt;
      done_next  = 1'b0;
      load_cfg   = 1'b0;
      lfsr_step  = 1'b0;
    end
  end

  // FSM state, word index, cycle counter, transfer count and done pulse.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      cnt      <= '0;
      sent_cnt <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      idx      <= idx_next;
      cnt      <= cnt_next;
      sent_cnt <= sent_next;
      done     <= done_next;
    end
  end

  // Shadow copy of the run configuration, taken when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      wait_q    <= '0;
      gap_en_q  <= 1'b0;
      gap_max_q <= '0;
      loop_q    <= 1'b0;
    end else if (load_cfg) begin
      len_q     <= cfg_len;
      wait_q    <= cfg_wait;
      gap_en_q  <= cfg_gap_en;
      gap_max_q <= cfg_gap_max;
      loop_q    <= cfg_loop;
    end
  end

endmodule

// File: tb/tb_bfm_stream_xmit.sv
// Self-checking bench for bfm_stream_xmit: stimulus pushes expected words into a
// scoreboard, a negedge monitor pops and compares each transfer and checks gap lengths
// against an independent LFSR model.
module tb_bfm_stream_xmit;

  localparam int          DATA_W = 257;
  localparam int          DEPTH  = 32;
  localparam int          AW     = 5;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_we;
  logic [AW-1:0]     ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic [AW:0]       cfg_len;
  logic [15:0]       cfg_wait;
  logic              cfg_gap_en;
  logic [7:0]        cfg_gap_max;
  logic              cfg_loop;
  logic              start;
  logic              abort;
  logic              hold;
  logic              tx_rdy;
  logic              tx_vld;
  logic [DATA_W-1:0] tx_data;
  logic              tx_last;
  logic              busy;
  logic              done;
  logic [31:0]       sent_cnt;

  bfm_stream_xmit #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .SEED   (SEED)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .cfg_len     (cfg_len),
    .cfg_wait    (cfg_wait),
    .cfg_gap_en  (cfg_gap_en),
    .cfg_gap_max (cfg_gap_max),
    .cfg_loop    (cfg_loop),
    .start       (start),
    .abort       (abort),
    .hold        (hold),
    .tx_rdy      (tx_rdy),
    .tx_vld      (tx_vld),
    .tx_data     (tx_data),
    .tx_last     (tx_last),
    .busy        (busy),
    .done        (done),
    .sent_cnt    (sent_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              done_after;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] mem_model [DEPTH];
  int                tests = 0;
  int                fails = 0;

  // Run context read by the monitor.
  bit gap_check   = 1'b0;
  bit run_gap_en  = 1'b0;
  int run_gap_max = 0;
  bit run_loop    = 1'b0;
  bit len0_due    = 1'b0;

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Polynomial x^16+x^14+x^13+x^11+1, Galois form: shift right, fold taps in when a 1 drops out.
  function automatic logic [15:0] lfsr_model(input logic [15:0] s);
    int          taps [4] = '{16, 14, 13, 11};
    logic [15:0] mask     = '0;
    foreach (taps[i]) mask[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w = '0;
    for (int i = 0; i < 9; i++) w = {w[DATA_W-33:0], 32'($urandom())};
    return w;
  endfunction

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [15:0]       lfsr_m    = SEED;
    bit                measuring = 1'b0;
    int                idle      = 0;
    int                exp_gap   = 0;
    bit                pending   = 1'b0;
    logic [DATA_W-1:0] pend_data = '0;
    bit                prev_done = 1'b0;
    bit                due;
    exp_t              e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lfsr_m    = SEED;
        measuring = 1'b0;
        pending   = 1'b0;
        prev_done = 1'b0;
      end else begin
        due = prev_done | len0_due;
        if (due || done) check("done_pulse", done, due);
        prev_done = 1'b0;
        if (tx_last) check("last_gated_by_vld", tx_vld, 1'b1);

        if (measuring) begin
          if (tx_vld) begin
            check("gap_len", idle, exp_gap);
            measuring = 1'b0;
          end else if (!busy) begin
            measuring = 1'b0;
          end else begin
            idle++;
            if (idle > 300) begin
              check("gap_timeout", idle, exp_gap);
              measuring = 1'b0;
            end
          end
        end

        if (tx_vld && pending) check("stall_data", tx_data, pend_data);
        if (!busy) pending = 1'b0;

        if (tx_vld && tx_rdy) begin
          lfsr_m  = lfsr_model(lfsr_m);
          pending = 1'b0;
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_xfer: got data %0h with no word expected", tx_data);
          end else begin
            e = sb.pop_front();
            check("xfer_data", tx_data, e.data);
            check("xfer_last", tx_last, e.last);
            prev_done = e.done_after;
            if (gap_check && !(e.last && !run_loop)) begin
              exp_gap   = (run_gap_en && !e.last) ? int'(lfsr_m) % (run_gap_max + 1) : 0;
              idle      = 0;
              measuring = 1'b1;
            end
          end
        end else if (tx_vld && !tx_rdy) begin
          pending   = 1'b1;
          pend_data = tx_data;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [DATA_W-1:0] d);
    ld_we   = 1'b1;
    ld_addr = AW'(addr);
    ld_data = d;
    tick();
    ld_we   = 1'b0;
    mem_model[addr] = d;
  endtask

  task automatic start_run(input int len, input int wait_c, input bit gen, input int gmax,
                           input bit loop, input int n_exp);
    exp_t e;
    cfg_len     = (AW+1)'(len);
    cfg_wait    = 16'(wait_c);
    cfg_gap_en  = gen;
    cfg_gap_max = 8'(gmax);
    cfg_loop    = loop;
    run_gap_en  = gen;
    run_gap_max = gmax;
    run_loop    = loop;
    for (int k = 0; k < n_exp; k++) begin
      e.data       = mem_model[k % len];
      e.last       = ((k % len) == len - 1);
      e.done_after = e.last && !loop && (k == n_exp - 1);
      sb.push_back(e);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic first_vld(input string name, input int exp_k);
    int k = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (tx_vld) begin
        k = i;
        break;
      end
    end
    check(name, k, exp_k);
  endtask

  task automatic wait_idle(input string name, input int exp_sent);
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_idle"}, ok, 1'b1);
    check({name, "_sent"}, sent_cnt, exp_sent);
    check({name, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic wait_xfers(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < 500 && seen < n; i++) begin
      @(negedge clk);
      if (tx_vld && tx_rdy) seen++;
    end
    check({name, "_xfers"}, seen, n);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stimulus
    rst_n = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    cfg_len = '0; cfg_wait = '0; cfg_gap_en = 1'b0; cfg_gap_max = '0; cfg_loop = 1'b0;
    start = 1'b0; abort = 1'b0; hold = 1'b0; tx_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_vld", tx_vld, 1'b0);
    check("rst_last", tx_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sent", sent_cnt, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: four words back-to-back, first valid one cycle after start.
    for (int i = 0; i < 4; i++) load(i, DATA_W'(i + 1));
    gap_check = 1'b1;
    start_run(4, 0, 1'b0, 0, 1'b0, 4);
    first_vld("t1_latency", 1);
    wait_idle("t1", 4);

    // T2: start delay of 5 cycles.
    tick();
    start_run(1, 5, 1'b0, 0, 1'b0, 1);
    first_vld("t2_latency", 6);
    wait_idle("t2", 1);

    // T3: ready toggling 1-0-0-1 then random, hold pulses, write attempt while busy.
    for (int i = 0; i < 16; i++) load(i, rand_word());
    gap_check = 1'b0;
    start_run(12, 2, 1'b1, 2, 1'b0, 12);
    begin
      bit rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      for (int c = 0; c < 600 && busy; c++) begin
        tx_rdy  = (c < 4) ? rdy_pat[c] : 1'($urandom_range(0, 1));
        hold    = (c == 6 || c == 7) ? 1'b1 : ($urandom_range(0, 9) == 0);
        ld_we   = (c == 3);
        ld_addr = AW'(11);
        ld_data = ~mem_model[11];
        tick();
      end
    end
    tx_rdy = 1'b1; hold = 1'b0; ld_we = 1'b0;
    wait_idle("t3", 12);

    // T4: random gaps, lengths checked against the model LFSR; includes len == DEPTH.
    tick();
    for (int i = 0; i < DEPTH; i++) load(i, rand_word());
    gap_check = 1'b1;
    start_run(8, 0, 1'b1, 3, 1'b0, 8);
    wait_idle("t4a", 8);
    tick();
    start_run(8, 0, 1'b1, 3, 1'b0, 8);
    wait_idle("t4b", 8);
    tick();
    start_run(DEPTH, 1, 1'b1, 7, 1'b0, DEPTH);
    wait_idle("t4c", DEPTH);
    tick();
    start_run(5, 0, 1'b1, 0, 1'b0, 5);
    wait_idle("t4d", 5);

    // T5: loop of three words, aborted after seven transfers.
    tick();
    for (int i = 0; i < 3; i++) load(i, DATA_W'(i + 1));
    gap_check = 1'b0;
    start_run(3, 0, 1'b0, 0, 1'b1, 7);
    wait_xfers("t5", 7);
    tick();
    tx_rdy = 1'b0;
    abort  = 1'b1;
    tick();
    abort  = 1'b0;
    tx_rdy = 1'b1;
    @(negedge clk);
    check("t5_busy_after_abort", busy, 1'b0);
    check("t5_vld_after_abort", tx_vld, 1'b0);
    check("t5_sent", sent_cnt, 7);
    check("t5_sb_empty", sb.size(), 0);

    // T6a: zero-length run gives only a done pulse.
    tick();
    start_run(0, 0, 1'b0, 0, 1'b0, 0);
    len0_due = 1'b1;
    @(negedge clk);
    check("t6a_vld", tx_vld, 1'b0);
    check("t6a_busy", busy, 1'b0);
    check("t6a_sent", sent_cnt, 0);
    tick();
    len0_due = 1'b0;

    // T6b: start and cfg changes while busy are ignored.
    gap_check = 1'b1;
    start_run(4, 0, 1'b0, 0, 1'b0, 4);
    tick();
    cfg_len = 6'd2; cfg_wait = 16'd3; cfg_loop = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idle("t6b", 4);

    // T6c: abort and start together in idle: abort wins.
    tick();
    cfg_len = 6'd3; cfg_wait = 16'd0; cfg_loop = 1'b0;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t6c_busy", busy, 1'b0);
    check("t6c_sent", sent_cnt, 4);

    // T6d: reset mid-run returns to reset values; memory and LFSR seed behaviour after.
    tick();
    gap_check = 1'b0;
    start_run(6, 0, 1'b0, 0, 1'b0, 6);
    wait_xfers("t6d", 2);
    tick();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("t6d_rst_busy", busy, 1'b0);
    check("t6d_rst_vld", tx_vld, 1'b0);
    check("t6d_rst_sent", sent_cnt, 0);
    check("t6d_rst_done", done, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    gap_check = 1'b1;
    start_run(3, 0, 1'b0, 0, 1'b0, 3);
    wait_idle("t6d_mem", 3);
    tick();
    start_run(6, 0, 1'b1, 3, 1'b0, 6);
    wait_idle("t6d_seed", 6);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

endmodule
